// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: rotating active-low column strobe, per-scan
// classification of low row bits, and press/release debouncing over whole scans.
module keypad_scan_4x4 #(
    parameter int unsigned N_SCAN         = 18,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       Clk_signal,
    input  logic       Reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    state_t            state, state_n;
    logic [3:0]        rows_m, rows_s;
    logic [N_SCAN-1:0] presc;
    logic              tick, scan_end;
    logic [1:0]        col_idx;
    logic [1:0]        acc_cnt;
    logic [3:0]        acc_code;
    logic [2:0]        col_lows;
    logic [2:0]        sum_lows;
    logic [1:0]        total;
    logic [1:0]        first_row;
    logic              found;
    logic [3:0]        res_code;
    logic              res_none, res_single;
    logic [3:0]        cnt, cnt_n;
    logic [3:0]        cand, cand_n;
    logic [3:0]        code_n;
    logic              down_n, valid_n;

    assign tick     = &presc;
    assign scan_end = tick && (col_idx == 2'd3);

    always_ff @(posedge Clk_signal or negedge Reset) begin
        if (!Reset) begin
            rows_m <= '1;
            rows_s <= '1;
        end else begin
            rows_m <= rows;
            rows_s <= rows_m;
        end
    end

    always_ff @(posedge Clk_signal or negedge Reset) begin
        if (!Reset) begin
            presc   <= '0;
            col_idx <= '0;
            cols    <= 4'b1110;
        end else begin
            presc <= presc + N_SCAN'(1);
            if (tick) begin
                col_idx <= col_idx + 2'd1;
                cols    <= ~(4'b0001 << (col_idx + 2'd1));
            end
        end
    end

    // Low-bit count saturates at 2: only NONE / SINGLE / MULTI matter.
    always_comb begin
        col_lows  = '0;
        first_row = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            col_lows = col_lows + {2'b00, ~rows_s[i]};
            if (!rows_s[i] && !found) begin
                first_row = i[1:0];
                found     = 1'b1;
            end
        end
        sum_lows   = {1'b0, acc_cnt} + col_lows;
        total      = (sum_lows >= 3'd2) ? 2'd2 : sum_lows[1:0];
        res_code   = (acc_cnt != 2'd0) ? acc_code : {first_row, col_idx};
        res_none   = (total == 2'd0);
        res_single = (total == 2'd1);
    end

    always_ff @(posedge Clk_signal or negedge Reset) begin
        if (!Reset) begin
            acc_cnt  <= '0;
            acc_code <= '0;
        end else if (scan_end) begin
            acc_cnt  <= '0;
            acc_code <= '0;
        end else if (tick) begin
            acc_cnt  <= total;
            acc_code <= res_code;
        end
    end

    always_ff @(posedge Clk_signal or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        down_n  = key_down;
        valid_n = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (res_single) begin
                        cand_n = res_code;
                        if (DS == 4'd1) begin
                            code_n  = res_code;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = PRESSED;
                        end else begin
                            cnt_n   = 4'd1;
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (res_single && (res_code == cand)) begin
                        if (cnt + 4'd1 == DS) begin
                            code_n  = cand;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = PRESSED;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (res_none) begin
                        if (DS == 4'd1) begin
                            down_n  = 1'b0;
                            cnt_n   = '0;
                            state_n = IDLE;
                        end else begin
                            cnt_n   = 4'd1;
                            state_n = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (res_none) begin
                        if (cnt + 4'd1 == DS) begin
                            down_n  = 1'b0;
                            cnt_n   = '0;
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = PRESSED;
                    end
                end
                default: begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: an ideal keypad model drives rows from cols, and a
// scan-level debounce model predicts key_valid / key_down / key_code.
module tb_keypad_scan_4x4;

    localparam int DS   = 3;
    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  rows, cols, key_code;
    logic        key_valid, key_down;
    logic        force_en = 1'b1;
    logic [3:0]  rows_force = 4'hF;
    logic [15:0] keys = '0;

    int vectors = 0;
    int miscompares = 0;

    bit         m_down;
    int         m_streak;
    int         m_cand;
    logic [3:0] m_code;

    keypad_scan_4x4 #(.N_SCAN(2), .DEBOUNCE_SCANS(DS)) dut (
        .Clk_signal (clk),
        .Reset      (rst_n),
        .rows       (rows),
        .cols       (cols),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_down   (key_down)
    );

    always #5 clk = ~clk;

    // Key index r*4+c pulls row r low while column c is strobed.
    function automatic logic [3:0] keypad_rows(input logic [3:0] c, input logic [15:0] k);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (k[rr*4+cc] && !c[cc]) r[rr] = 1'b0;
        return r;
    endfunction

    assign rows = force_en ? rows_force : keypad_rows(cols, keys);

    // -1 = no key, -2 = several keys, otherwise the single key index.
    function automatic int scan_result(input logic [15:0] k);
        if ($countones(k) == 0) return -1;
        if ($countones(k) > 1)  return -2;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_down   = 1'b0;
        m_streak = 0;
        m_cand   = 0;
        m_code   = 4'h0;
    endtask

    task automatic model_scan(input logic [15:0] k, output bit pulse);
        int res;
        res   = scan_result(k);
        pulse = 1'b0;
        if (!m_down) begin
            if (res >= 0 && m_streak > 0 && res == m_cand) m_streak++;
            else if (res >= 0 && m_streak == 0) begin
                m_cand   = res;
                m_streak = 1;
            end else m_streak = 0;
            if (m_streak == DS) begin
                m_down   = 1'b1;
                m_code   = 4'(m_cand);
                m_streak = 0;
                pulse    = 1'b1;
            end
        end else begin
            if (res == -1) m_streak++;
            else m_streak = 0;
            if (m_streak == DS) begin
                m_down   = 1'b0;
                m_streak = 0;
            end
        end
    endtask

    // Called at #1 after a scan-boundary edge; runs one full 16-clock scan.
    task automatic run_scan(input logic [15:0] k);
        bit         pulse;
        logic [3:0] ec;
        keys = k;
        for (int j = 1; j <= SCAN; j++) begin
            @(posedge clk);
            #1;
            ec = 4'b0001 << ((j / 4) % 4);
            check("cols", cols, ~ec);
            if (j == SCAN) begin
                model_scan(k, pulse);
                check("key_valid", {3'b000, key_valid}, {3'b000, pulse});
                check("key_down", {3'b000, key_down}, {3'b000, m_down});
                check("key_code", key_code, m_code);
            end else begin
                check("key_valid_quiet", {3'b000, key_valid}, 4'h0);
            end
        end
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_scan(k);
    endtask

    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K2  = 16'h0004;
    localparam logic [15:0] K15 = 16'h8000;

    initial begin
        logic [15:0] rk;
        int          sel, len;
        model_reset();
        #2 rst_n = 1'b0;

        // Reset held with rows toggling.
        for (int i = 0; i < 10; i++) begin
            rows_force = 4'($urandom);
            @(posedge clk);
            #1;
            check("rst_cols", cols, 4'b1110);
            check("rst_code", key_code, 4'h0);
            check("rst_valid", {3'b000, key_valid}, 4'h0);
            check("rst_down", {3'b000, key_down}, 4'h0);
        end
        force_en = 1'b0;
        keys     = '0;
        rst_n    = 1'b1;

        hold(16'h0, 1);
        hold(K9, 8);             // press key 9
        hold(16'h0, 3);          // release: key_down falls after 3 scans
        hold(K15, 4);            // press key 15
        hold(16'h0, 1);          // brief release
        hold(K15, 2);            // re-press during RELEASE: no new pulse
        hold(16'h0, 4);

        // Bounce
        hold(K9, 1);
        hold(16'h0, 1);
        hold(K9, 1);
        hold(16'h0, 3);

        // Two keys, then one released
        hold(K9 | K2, 6);
        hold(K9, 4);
        hold(16'h0, 4);

        // Reset while PRESSED
        hold(K9, 3);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_down", {3'b000, key_down}, 4'h0);
        check("async_code", key_code, 4'h0);
        check("async_valid", {3'b000, key_valid}, 4'h0);
        check("async_cols", cols, 4'b1110);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(K9, 4);
        hold(16'h0, 4);

        // Randomized key activity
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            rk  = '0;
            if (sel >= 4) rk[$urandom_range(0, 15)] = 1'b1;
            if (sel == 9) rk[$urandom_range(0, 15)] = 1'b1;
            len = $urandom_range(1, 5);
            hold(rk, len);
        end
        hold(16'h0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
- Reader for a 4x4 matrix keypad on the board, sharing the time-multiplexed strobing scheme used by the 7-segment display driver.
- Rotates an active-low column strobe and samples the four active-low row inputs at the end of each column dwell.
- Debounces the result over whole scans and reports each clean key press once as a 4-bit code with a one-cycle valid pulse.
- Output feeds the front-panel control logic and the display path.

Parameters:
- N_SCAN, 18: column dwell is 2^N_SCAN clocks (2.62 ms at 100 MHz); legal range >= 2.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to accept a press or a release; legal range 1..15.

Ports:
- Clk_signal  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-low reset.
- rows  in  4  keypad row lines, active-low, asynchronous to the clock.
- cols  out  4  column strobes, active-low, exactly one bit low at a time.
- key_code  out  4  code of the last accepted key, {row[1:0], col[1:0]}.
- key_valid  out  1  one-cycle pulse when a new press is accepted.
- key_down  out  1  high from press acceptance until release acceptance.

Behaviour:
- Reset (Reset=0, async): cols=4'b1110, key_code=0, key_valid=0, key_down=0, col_idx=0, prescaler=0, FSM=IDLE, debounce count=0, synchronizer=4'b1111, scan accumulator cleared.
- rows pass through a 2-flop synchronizer; only rows_s is used.
- Prescaler:
  - N_SCAN-bit free-running counter.
  - tick = counter all-ones.
  - On tick, col_idx increments mod 4, wrapping 3->0.
  - cols = ~(4'b0001 << col_idx), registered. Order: 1110, 1101, 1011, 0111.
- Sampling and scan result:
  - On tick, rows_s is sampled for the current col_idx. This is the end of dwell, so rows have settled.
  - The per-scan accumulator records the number of low row bits seen and the {row, col} of the first low bit.
  - The scan ends on the tick where col_idx==3. Result is:
    - NONE: zero low bits.
    - SINGLE(code): exactly one low bit in the whole scan.
    - MULTI: two or more low bits, in any column or columns.
  - The accumulator clears for the next scan.
- FSM, evaluated only at scan end:
  - IDLE: SINGLE(k) -> cand=k, cnt=1, go to DEBOUNCE. If DEBOUNCE_SCANS==1, go straight to accept. NONE or MULTI -> stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS, accept: key_code<=cand, key_valid=1 for exactly the next clock, key_down<=1, go to PRESSED.
    - Any other result -> IDLE, cnt=0.
  - PRESSED: NONE -> cnt=1, go to RELEASE. SINGLE of another key or MULTI -> stay; no new event (no rollover).
  - RELEASE:
    - NONE -> cnt+1. At DEBOUNCE_SCANS, key_down<=0, go to IDLE.
    - Any non-NONE -> PRESSED, cnt=0.
- Latency: key_valid asserts 1 clock after the scan-end tick of the DEBOUNCE_SCANS-th consecutive SINGLE scan.
- key_code holds its value until the next accepted press; it is not cleared on release.
- key_valid never asserts in consecutive cycles. At most one pulse per press/release cycle.
- Reset mid-operation: all state returns to reset values immediately. The first scan after reset starts at column 0.

Test Plan (N_SCAN=2, DEBOUNCE_SCANS=3; dwell 4 clocks, scan 16 clocks):
1. Hold Reset=0 for 10 clocks while toggling rows -> cols=1110, key_code=0, key_valid=0, key_down=0 throughout. After release, cols step 1110->1101->1011->0111->1110 every 4 clocks.
2. Model key row2/col1: rows=4'b1011 whenever cols=1101, else 1111; held 8 scans -> exactly one key_valid pulse, 1 clock after the 3rd scan-end tick; key_code=4'd9; key_down=1 for the rest of the hold.
3. Bounce: key 9 present for 1 scan, absent for 1, present for 1, then released -> no key_valid pulse; key_down stays 0.
4. Keys 9 and 4'd2 (row0/col2) held together for 6 scans -> no pulse. Then release key 2 only -> pulse with key_code=9 after 3 SINGLE scans.
5. Release after test 2 -> key_down falls 3 scans later. Re-press key 4'd15 (row3/col3) -> new pulse, key_code=15. A re-press during RELEASE after 1 NONE scan -> back to PRESSED, no pulse, key_down stays 1.
6. Assert Reset in PRESSED, 2 clocks after a key_valid pulse -> key_down and key_code drop to 0 asynchronously. After deassert with the key still held -> new pulse after 3 full scans.
